// File: rtl/mult_cdb_buffer_if.sv
// Bus between the multiplier pipeline / branch logic / CDB arbiter and the
// mult result buffer.
//   master : upstream side; drives multiplier results, branch recovery and
//            cdb_grant, observes the CDB request, issue throttle and count.
//   slave  : mult_cdb_buffer itself.
// Signals:
//   in_valid, in_product[63:0], in_dest_reg[5:0], in_NPC[63:0], in_bmask[3:0]
//   br_rec_en_1/2, br_marker_1/2[2:0], br_mispre_1/2
//   cdb_grant, cdb_req, cdb_product[63:0], cdb_dest_reg[5:0], cdb_NPC[63:0]
//   issue_block, count[PTR_W:0]
interface mult_cdb_buffer_if #(
    parameter int unsigned PTR_W = 3
);
    logic              in_valid;
    logic [63:0]       in_product;
    logic [5:0]        in_dest_reg;
    logic [63:0]       in_NPC;
    logic [3:0]        in_bmask;

    logic              br_rec_en_1;
    logic              br_rec_en_2;
    logic [2:0]        br_marker_1;
    logic [2:0]        br_marker_2;
    logic              br_mispre_1;
    logic              br_mispre_2;

    logic              cdb_grant;
    logic              cdb_req;
    logic [63:0]       cdb_product;
    logic [5:0]        cdb_dest_reg;
    logic [63:0]       cdb_NPC;

    logic              issue_block;
    logic [PTR_W:0]    count;

    modport master (
        output in_valid, in_product, in_dest_reg, in_NPC, in_bmask,
        output br_rec_en_1, br_rec_en_2, br_marker_1, br_marker_2,
        output br_mispre_1, br_mispre_2,
        output cdb_grant,
        input  cdb_req, cdb_product, cdb_dest_reg, cdb_NPC,
        input  issue_block, count
    );

    modport slave (
        input  in_valid, in_product, in_dest_reg, in_NPC, in_bmask,
        input  br_rec_en_1, br_rec_en_2, br_marker_1, br_marker_2,
        input  br_mispre_1, br_mispre_2,
        input  cdb_grant,
        output cdb_req, cdb_product, cdb_dest_reg, cdb_NPC,
        output issue_block, count
    );
endinterface

// File: rtl/mult_cdb_buffer.sv
// Result buffer behind the non-stallable 4-stage multiplier.
// Holds finished products (with dest_reg, NPC, bmask) in an in-order circular
// queue, offers the oldest live one to the CDB arbiter via req/grant, applies
// branch squash / bmask clear to every held entry, and throttles mult issue so
// every in-flight multiply always has a free slot.
// Ports:
//   clock  : system clock, posedge
//   reset  : synchronous, active-high
//   bus    : mult_cdb_buffer_if.slave (result in, branch recovery, CDB out,
//            issue_block, count)
// Optional feature: define MULT_BUF_BYPASS_EN to let a result arriving at an
// empty buffer drive the CDB request in the same cycle.
module mult_cdb_buffer #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned PIPE_DEPTH = 4,
    parameter int unsigned PTR_W      = 3
) (
    input  logic             clock,
    input  logic             reset,
    mult_cdb_buffer_if.slave bus
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] BLOCK_AT = (PTR_W+1)'(DEPTH - PIPE_DEPTH);

    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [PTR_W:0]   count_q;

    logic             live_q    [DEPTH];
    logic [3:0]       bmask_q   [DEPTH];
    logic [63:0]      product_q [DEPTH];
    logic [5:0]       dest_q    [DEPTH];
    logic [63:0]      npc_q     [DEPTH];

    logic [3:0] kill_vec;
    logic [3:0] clear_vec;
    logic       nonempty;
    logic       head_kill;
    logic       head_req;
    logic       head_dead;
    logic       in_kill;
    logic       bypass;
    logic       pop;
    logic       push;

    // Branch recovery as bit vectors: Kill(m) = |(m & kill_vec),
    // cleared mask = m & ~clear_vec. Markers 4..7 match nothing.
    always_comb begin
        kill_vec  = '0;
        clear_vec = '0;
        if (bus.br_rec_en_1 && !bus.br_marker_1[2]) begin
            clear_vec[bus.br_marker_1[1:0]] = 1'b1;
            if (bus.br_mispre_1)
                kill_vec[bus.br_marker_1[1:0]] = 1'b1;
        end
        if (bus.br_rec_en_2 && !bus.br_marker_2[2]) begin
            clear_vec[bus.br_marker_2[1:0]] = 1'b1;
            if (bus.br_mispre_2)
                kill_vec[bus.br_marker_2[1:0]] = 1'b1;
        end
    end

    assign nonempty  = (count_q != '0);
    assign head_kill = |(bmask_q[head_q] & kill_vec);
    assign head_req  = nonempty & live_q[head_q] & ~head_kill;
    assign head_dead = nonempty & (~live_q[head_q] | head_kill);
    assign in_kill   = |(bus.in_bmask & kill_vec);

`ifdef MULT_BUF_BYPASS_EN
    assign bypass = ~nonempty & bus.in_valid & ~in_kill;
`else
    assign bypass = 1'b0;
`endif

    // Dead heads leave without a request; a granted bypass is never stored.
    assign pop  = (head_req & bus.cdb_grant) | head_dead;
    assign push = bus.in_valid & ~(bypass & bus.cdb_grant) & ((count_q != FULL_CNT) | pop);

    always_comb begin
        bus.cdb_req      = 1'b0;
        bus.cdb_product  = '0;
        bus.cdb_dest_reg = '0;
        bus.cdb_NPC      = '0;
        if (head_req) begin
            bus.cdb_req      = 1'b1;
            bus.cdb_product  = product_q[head_q];
            bus.cdb_dest_reg = dest_q[head_q];
            bus.cdb_NPC      = npc_q[head_q];
        end else if (bypass) begin
            bus.cdb_req      = 1'b1;
            bus.cdb_product  = bus.in_product;
            bus.cdb_dest_reg = bus.in_dest_reg;
            bus.cdb_NPC      = bus.in_NPC;
        end
    end

    assign bus.issue_block = (count_q >= BLOCK_AT);
    assign bus.count       = count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                live_q[i]  <= 1'b0;
                bmask_q[i] <= '0;
            end
        end else begin
            // Squash is latched into live so a later clear of the same bit
            // cannot resurrect an entry that was killed away from the head.
            for (int unsigned i = 0; i < DEPTH; i++) begin
                live_q[i]  <= live_q[i] & ~(|(bmask_q[i] & kill_vec));
                bmask_q[i] <= bmask_q[i] & ~clear_vec;
            end
            if (push) begin
                live_q[tail_q]    <= ~in_kill;
                bmask_q[tail_q]   <= bus.in_bmask & ~clear_vec;
                product_q[tail_q] <= bus.in_product;
                dest_q[tail_q]    <= bus.in_dest_reg;
                npc_q[tail_q]     <= bus.in_NPC;
                tail_q            <= tail_q + 1'b1;
            end
            if (pop)
                head_q <= head_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifndef SYNTHESIS
    // Upstream cannot stall, so a push into a full buffer loses a result.
    always_ff @(posedge clock) begin
        assert (reset || !(bus.in_valid && (count_q == FULL_CNT) && !pop))
            else $error("mult_cdb_buffer: overflow, incoming result dropped");
    end
`endif

endmodule

// File: tb/tb_mult_cdb_buffer.sv
module tb_mult_cdb_buffer;

    localparam int unsigned DEPTH      = 8;
    localparam int unsigned PIPE_DEPTH = 4;
    localparam int unsigned PTR_W      = 3;

    logic clock;
    logic reset;

    mult_cdb_buffer_if #(.PTR_W(PTR_W)) bus ();

    mult_cdb_buffer #(
        .DEPTH      (DEPTH),
        .PIPE_DEPTH (PIPE_DEPTH),
        .PTR_W      (PTR_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors    = 0;
    int miscompares = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Stimulus for the next cycle.
    bit        v_in;
    bit [63:0] p_in;
    bit [5:0]  d_in;
    bit [63:0] n_in;
    bit [3:0]  bm_in;
    bit        r1, mp1, r2, mp2;
    bit [2:0]  mk1, mk2;
    bit        g_in;

    // Reference model: queue of held results, oldest first.
    typedef struct {
        bit        live;
        bit [3:0]  bm;
        bit [63:0] prod;
        bit [5:0]  dest;
        bit [63:0] npc;
    } ent_t;
    ent_t q[$];

    function automatic bit m_kill(bit [3:0] m);
        bit k = 0;
        if (r1 && mp1 && mk1 < 4 && m[mk1[1:0]]) k = 1;
        if (r2 && mp2 && mk2 < 4 && m[mk2[1:0]]) k = 1;
        return k;
    endfunction

    function automatic bit [3:0] m_clear(bit [3:0] m);
        bit [3:0] r = m;
        if (r1 && mk1 < 4) r[mk1[1:0]] = 1'b0;
        if (r2 && mk2 < 4) r[mk2[1:0]] = 1'b0;
        return r;
    endfunction

    function automatic bit m_pops();
        if (q.size() == 0) return 0;
        return !q[0].live || m_kill(q[0].bm) || g_in;
    endfunction

    task automatic idle(input bit g);
        v_in = 0; p_in = '0; d_in = '0; n_in = '0; bm_in = '0;
        r1 = 0; mp1 = 0; mk1 = '0; r2 = 0; mp2 = 0; mk2 = '0;
        g_in = g;
    endtask

    // Drive one cycle, check every output against the model, advance the model.
    task automatic apply();
        int        cnt;
        bit        req, byp;
        bit [63:0] e_p, e_n;
        bit [5:0]  e_d;
        ent_t      e;
        @(negedge clock);
        bus.in_valid    = v_in;
        bus.in_product  = p_in;
        bus.in_dest_reg = d_in;
        bus.in_NPC      = n_in;
        bus.in_bmask    = bm_in;
        bus.br_rec_en_1 = r1;
        bus.br_mispre_1 = mp1;
        bus.br_marker_1 = mk1;
        bus.br_rec_en_2 = r2;
        bus.br_mispre_2 = mp2;
        bus.br_marker_2 = mk2;
        bus.cdb_grant   = g_in;
        #1;
        cnt = q.size();
        req = 0; byp = 0; e_p = '0; e_d = '0; e_n = '0;
        if (cnt != 0 && q[0].live && !m_kill(q[0].bm)) begin
            req = 1; e_p = q[0].prod; e_d = q[0].dest; e_n = q[0].npc;
        end
`ifdef MULT_BUF_BYPASS_EN
        if (cnt == 0 && v_in && !m_kill(bm_in)) begin
            byp = 1; req = 1; e_p = p_in; e_d = d_in; e_n = n_in;
        end
`endif
        check_eq("cdb_req",      bus.cdb_req,      req);
        check_eq("cdb_product",  bus.cdb_product,  e_p);
        check_eq("cdb_dest_reg", bus.cdb_dest_reg, e_d);
        check_eq("cdb_NPC",      bus.cdb_NPC,      e_n);
        check_eq("issue_block",  bus.issue_block,  64'(cnt >= int'(DEPTH - PIPE_DEPTH)));
        check_eq("count",        bus.count,        64'(cnt));
        if (cnt != 0 && (!q[0].live || m_kill(q[0].bm) || (req && g_in)))
            void'(q.pop_front());
        foreach (q[i]) begin
            if (m_kill(q[i].bm)) q[i].live = 0;
            q[i].bm = m_clear(q[i].bm);
        end
        if (v_in && !(byp && g_in) && q.size() < int'(DEPTH)) begin
            e.live = !m_kill(bm_in);
            e.bm   = m_clear(bm_in);
            e.prod = p_in;
            e.dest = d_in;
            e.npc  = n_in;
            q.push_back(e);
        end
    endtask

    task automatic drain();
        idle(1);
        repeat (12) apply();
    endtask

    task automatic push_one(input bit [63:0] p, input bit [3:0] bm, input bit g);
        idle(g);
        v_in = 1; p_in = p; d_in = 6'(p); n_in = 64'h1000 + p; bm_in = bm;
    endtask

    initial begin
        idle(0);
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        #1;
        check_eq("rst_req",   bus.cdb_req,     0);
        check_eq("rst_count", bus.count,       0);
        check_eq("rst_block", bus.issue_block, 0);
        check_eq("rst_prod",  bus.cdb_product, 0);
        reset = 1'b0;

        // Single result: product 42 to reg 5.
        push_one(64'd42, 4'b0000, 1); d_in = 6'd5;
        apply();
`ifndef MULT_BUF_BYPASS_EN
        idle(1); apply();
        check_eq("t1_req",  bus.cdb_req,      1);
        check_eq("t1_prod", bus.cdb_product,  42);
        check_eq("t1_dest", bus.cdb_dest_reg, 5);
`endif
        idle(1); apply();
        check_eq("t1_count", bus.count,   0);
        check_eq("t1_idle",  bus.cdb_req, 0);

        // Fill to 5 without grants, then broadcast in order.
        for (int k = 1; k <= 5; k++) begin
            push_one(64'(k), 4'b0000, 0);
            apply();
        end
        idle(0); apply();
        check_eq("t2_count", bus.count,       5);
        check_eq("t2_block", bus.issue_block, 1);
        idle(1); apply();
        check_eq("t2_first", bus.cdb_product, 1);
        idle(1); apply();
        idle(1); apply();
        check_eq("t2_block_lo", bus.issue_block, 0);
        drain();

        // Middle survivor of a mispredict on marker 1.
        push_one(64'd11, 4'b0010, 0); apply();
        push_one(64'd12, 4'b0000, 0); apply();
        push_one(64'd13, 4'b0010, 0); apply();
        idle(1); r1 = 1; mp1 = 1; mk1 = 3'd1; apply();
        idle(1); apply();
        check_eq("t3_mid", bus.cdb_product, 12);
        idle(1); apply();
        idle(1); apply();
        check_eq("t3_count", bus.count, 0);

        // Correct prediction clears the bit; later mispredict leaves it alone.
        push_one(64'd21, 4'b0010, 0); apply();
        idle(0); r2 = 1; mp2 = 0; mk2 = 3'd1; apply();
        idle(0); r1 = 1; mp1 = 1; mk1 = 3'd1; apply();
        check_eq("t4_req", bus.cdb_req, 1);
        drain();

        // Killed on arrival still takes a slot; out-of-range marker kills nothing.
        push_one(64'd31, 4'b0100, 1); r1 = 1; mp1 = 1; mk1 = 3'd2; apply();
        idle(1); apply();
        check_eq("t5_count", bus.count,   1);
        check_eq("t5_req",   bus.cdb_req, 0);
        push_one(64'd32, 4'b0100, 0); r1 = 1; mp1 = 1; mk1 = 3'd5; apply();
        idle(0); apply();
        check_eq("t5_live", bus.cdb_req, 1);
        drain();

`ifdef MULT_BUF_BYPASS_EN
        push_one(64'd9, 4'b0000, 1); apply();
        check_eq("t6_req",  bus.cdb_req,     1);
        check_eq("t6_prod", bus.cdb_product, 9);
        idle(0); apply();
        check_eq("t6_count0", bus.count, 0);
        push_one(64'd9, 4'b0000, 0); apply();
        idle(1); apply();
        check_eq("t6_count1", bus.count,       1);
        check_eq("t6_bcast",  bus.cdb_product, 9);
        drain();
`endif

        // Randomized traffic with alternating grant pressure.
        for (int i = 0; i < 3000; i++) begin
            v_in  = ($urandom_range(0, 99) < 60);
            p_in  = {$urandom, $urandom};
            d_in  = 6'($urandom);
            n_in  = {$urandom, $urandom};
            bm_in = 4'($urandom) & 4'($urandom);
            r1    = ($urandom_range(0, 99) < 20);
            mp1   = 1'($urandom);
            mk1   = 3'($urandom);
            r2    = ($urandom_range(0, 99) < 20);
            mp2   = 1'($urandom);
            mk2   = 3'($urandom);
            g_in  = ((i / 200) % 2 == 0) ? ($urandom_range(0, 99) < 85)
                                          : ($urandom_range(0, 99) < 15);
            if (q.size() >= int'(DEPTH) && !m_pops())
                v_in = 0;
            apply();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
